// File: rtl/ssd_scan_driver_if.sv
// +----------------------------------------------------------------------------+
// | Module   : ssd_scan_driver_if                                              |
// | Brief    : Load-side bus between score logic and the seven-segment driver. |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 8
) ();
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic                    lz_blank;
  logic [3:0]              brightness;
  logic                    load_ack;

  modport master (
    output value, dp, digit_en, load, lz_blank, brightness,
    input  load_ack
  );

  modport slave (
    input  value, dp, digit_en, load, lz_blank, brightness,
    output load_ack
  );
endinterface

`default_nettype wire

// File: rtl/ssd_scan_driver.sv
// +----------------------------------------------------------------------------+
// | Module   : ssd_scan_driver                                                 |
// | Brief    : Multiplexed 1-8 digit seven-segment driver with PWM brightness, |
// |            leading-zero blanking and a frame-synchronous double buffer.    |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module ssd_scan_driver #(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_LOG2 = 18
) (
  input  logic                  ClkPort,
  input  logic                  Reset,
  ssd_scan_driver_if.slave      bus,
  output logic [NUM_DIGITS-1:0] An,
  output logic [7:0]            Cath,
  output logic                  frame_start
);

  localparam int                 c_IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_DIV_LOG2-1:0] r_presc;
  logic [c_IDX_W-1:0]       r_idx;
  logic [4*NUM_DIGITS-1:0]  r_act_value;
  logic [NUM_DIGITS-1:0]    r_act_dp;
  logic [NUM_DIGITS-1:0]    r_act_en;
  logic [4*NUM_DIGITS-1:0]  r_pend_value;
  logic [NUM_DIGITS-1:0]    r_pend_dp;
  logic [NUM_DIGITS-1:0]    r_pend_en;
  logic                     r_pend_flag;
  logic                     r_bnd_d;
  logic                     r_ack_d;
  logic                     r_load_ack;

  logic                     w_wrap;
  logic                     w_boundary;
  logic [3:0]               w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]    w_zero;
  logic [NUM_DIGITS-1:0]    w_blank;
  logic [3:0]               w_cur_nib;
  logic [3:0]               w_phase;
  logic                     w_an_on;
  logic [NUM_DIGITS-1:0]    w_an_next;
  logic [6:0]               w_seg;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  assign w_wrap     = &r_presc;
  assign w_boundary = w_wrap && (r_idx == c_LAST_IDX);

  // Scan position plus double buffer; a load in the boundary cycle stays pending.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_en     <= '1;
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_en    <= '0;
      r_pend_flag  <= 1'b0;
      r_bnd_d      <= 1'b0;
      r_ack_d      <= 1'b0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_wrap) begin
        r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      r_bnd_d <= w_boundary;
      r_ack_d <= w_boundary && r_pend_flag;
      if (w_boundary && r_pend_flag) begin
        r_act_value <= r_pend_value;
        r_act_dp    <= r_pend_dp;
        r_act_en    <= r_pend_en;
      end
      if (bus.load) begin
        r_pend_value <= bus.value;
        r_pend_dp    <= bus.dp;
        r_pend_en    <= bus.digit_en;
        r_pend_flag  <= 1'b1;
      end else if (w_boundary) begin
        r_pend_flag  <= 1'b0;
      end
    end
  end

  // A digit is blanked when it and every digit above it hold zero.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign w_nib[g]  = r_act_value[4*g +: 4];
    assign w_zero[g] = (w_nib[g] == 4'h0);
    if (g == 0) begin : g_units
      assign w_blank[g] = 1'b0;
    end else begin : g_upper
      assign w_blank[g] = bus.lz_blank && (&w_zero[NUM_DIGITS-1:g]);
    end
  end

  assign w_cur_nib = w_nib[r_idx];
  assign w_phase   = r_presc[SCAN_DIV_LOG2-1 -: 4];
  assign w_an_on   = r_act_en[r_idx] && (w_phase <= bus.brightness);
  assign w_seg     = w_blank[r_idx] ? 7'h7F : f_decode(w_cur_nib);

  always_comb begin
    w_an_next = '1;
    if (w_an_on) begin
      w_an_next[r_idx] = 1'b0;
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      An          <= '1;
      Cath        <= 8'hFF;
      frame_start <= 1'b0;
      r_load_ack  <= 1'b0;
    end else begin
      An          <= w_an_next;
      Cath        <= {w_seg, ~r_act_dp[r_idx]};
      frame_start <= r_bnd_d;
      r_load_ack  <= r_ack_d;
    end
  end

  assign bus.load_ack = r_load_ack;

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_ssd_scan_driver                                              |
// | Brief    : Directed self-checking bench, 4 digits with 16-cycle slots.     |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ssd_scan_driver;

  logic       clk;
  logic       rst;
  logic [3:0] An;
  logic [7:0] Cath;
  logic       frame_start;
  int         n_pass;
  int         n_total;

  ssd_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  ssd_scan_driver #(
    .NUM_DIGITS   (4),
    .SCAN_DIV_LOG2(4)
  ) u_dut (
    .ClkPort    (clk),
    .Reset      (rst),
    .bus        (bus),
    .An         (An),
    .Cath       (Cath),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
    bus.value    = v;
    bus.dp       = d;
    bus.digit_en = en;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic wait_fs(output bit ok, output int acks);
    ok   = 1'b0;
    acks = 0;
    for (int k = 0; k < 200; k++) begin
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (bus.load_ack === 1'b1) acks++;
      @(negedge clk);
    end
  endtask

  // Records one 64-cycle frame starting at the frame_start cycle; ends on the next one.
  task automatic capture_frame(output logic [31:0] cath, output logic [31:0] lowc,
                               output int acks, output int bad);
    int d;
    cath = '0;
    lowc = '0;
    acks = 0;
    bad  = 0;
    for (int c = 0; c < 64; c++) begin
      d = c / 16;
      if (c % 16 == 0) cath[d*8 +: 8] = Cath;
      for (int j = 0; j < 4; j++) begin
        if (An[j] === 1'b0) begin
          if (j == d) lowc[j*8 +: 8] = lowc[j*8 +: 8] + 8'd1;
          else        bad++;
        end
      end
      if (bus.load_ack === 1'b1) acks++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (An !== 4'b1111) $display("FAIL reset_an: got %b expected 1111", An); else n_pass++;
    n_total++; if (Cath !== 8'hFF) $display("FAIL reset_cath: got %h expected ff", Cath); else n_pass++;
    n_total++; if (bus.load_ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", bus.load_ack); else n_pass++;
    n_total++; if (frame_start !== 1'b0) $display("FAIL reset_fs: got %b expected 0", frame_start); else n_pass++;
    rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((k - 1) / 16));
      n_total++; if (An !== exp_an) $display("FAIL scan_an cyc %0d: got %b expected %b", k, An, exp_an); else n_pass++;
      n_total++; if (Cath !== 8'h03 || frame_start !== 1'b0)
        $display("FAIL scan_cath_fs cyc %0d: got %h/%b expected 03/0", k, Cath, frame_start); else n_pass++;
    end
    @(negedge clk);
    n_total++; if (frame_start !== 1'b1) $display("FAIL first_fs: got %b expected 1", frame_start); else n_pass++;
    n_total++; if (An !== 4'b1110) $display("FAIL first_fs_an: got %b expected 1110", An); else n_pass++;
    repeat (64) @(negedge clk);
    n_total++; if (frame_start !== 1'b1) $display("FAIL fs_period: got %b expected 1", frame_start); else n_pass++;
  endtask

  task automatic test_load_mid_frame();
    logic [31:0] cath, lowc;
    int acks, bad, early;
    repeat (20) @(negedge clk);
    pulse_load(16'h12AF, 4'b0100, 4'b1111);
    early = 0;
    for (int k = 0; k < 43; k++) begin
      if (Cath !== 8'h03 || bus.load_ack !== 1'b0) early++;
      @(negedge clk);
    end
    n_total++; if (early != 0) $display("FAIL load_early: got %0d changed cycles expected 0", early); else n_pass++;
    n_total++; if (frame_start !== 1'b1 || bus.load_ack !== 1'b1)
      $display("FAIL load_ack_align: got fs=%b ack=%b expected 1/1", frame_start, bus.load_ack); else n_pass++;
    capture_frame(cath, lowc, acks, bad);
    n_total++; if (cath !== 32'h9F24_1171) $display("FAIL load_digits: got %h expected 9f241171", cath); else n_pass++;
    n_total++; if (acks != 1) $display("FAIL load_ack_count: got %0d expected 1", acks); else n_pass++;
    n_total++; if (lowc !== 32'h1010_1010 || bad != 0)
      $display("FAIL load_anodes: got %h bad=%0d expected 10101010 bad=0", lowc, bad); else n_pass++;
    capture_frame(cath, lowc, acks, bad);
    n_total++; if (acks != 0 || cath !== 32'h9F24_1171)
      $display("FAIL load_hold: got acks=%0d %h expected 0 9f241171", acks, cath); else n_pass++;
  endtask

  task automatic test_lz_blank();
    logic [31:0] cath, lowc;
    int acks, bad;
    bit ok;
    bus.lz_blank = 1'b1;
    pulse_load(16'h0050, 4'b0000, 4'b1111);
    wait_fs(ok, acks);
    n_total++; if (!ok) $display("FAIL lz_wait: got timeout expected frame_start"); else n_pass++;
    capture_frame(cath, lowc, acks, bad);
    n_total++; if (cath !== 32'hFFFF_4903) $display("FAIL lz_0050: got %h expected ffff4903", cath); else n_pass++;
    n_total++; if (lowc !== 32'h1010_1010 || acks != 1)
      $display("FAIL lz_0050_an: got %h acks=%0d expected 10101010 acks=1", lowc, acks); else n_pass++;
    pulse_load(16'h0000, 4'b0000, 4'b1111);
    wait_fs(ok, acks);
    capture_frame(cath, lowc, acks, bad);
    n_total++; if (cath !== 32'hFFFF_FF03) $display("FAIL lz_0000: got %h expected ffffff03", cath); else n_pass++;
  endtask

  task automatic test_pwm_enable();
    logic [31:0] cath, lowc;
    int acks, bad;
    bit ok;
    bus.lz_blank   = 1'b0;
    bus.brightness = 4'd3;
    @(negedge clk);
    wait_fs(ok, acks);
    capture_frame(cath, lowc, acks, bad);
    n_total++; if (lowc !== 32'h0404_0404 || bad != 0)
      $display("FAIL pwm_3: got %h bad=%0d expected 04040404", lowc, bad); else n_pass++;
    bus.brightness = 4'd0;
    @(negedge clk);
    wait_fs(ok, acks);
    capture_frame(cath, lowc, acks, bad);
    n_total++; if (lowc !== 32'h0101_0101) $display("FAIL pwm_0: got %h expected 01010101", lowc); else n_pass++;
    bus.brightness = 4'd15;
    pulse_load(16'h0000, 4'b0000, 4'b1011);
    wait_fs(ok, acks);
    capture_frame(cath, lowc, acks, bad);
    n_total++; if (lowc !== 32'h1000_1010 || acks != 1)
      $display("FAIL digit_en: got %h acks=%0d expected 10001010 acks=1", lowc, acks); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] cath, lowc;
    int acks, bad;
    repeat (10) @(negedge clk);
    pulse_load(16'h1111, 4'b0000, 4'b1111);
    repeat (10) @(negedge clk);
    pulse_load(16'h2222, 4'b0000, 4'b1111);
    repeat (40) @(negedge clk);
    pulse_load(16'h3456, 4'b0000, 4'b1111);
    @(negedge clk);
    n_total++; if (frame_start !== 1'b1 || bus.load_ack !== 1'b1)
      $display("FAIL b2b_ack1: got fs=%b ack=%b expected 1/1", frame_start, bus.load_ack); else n_pass++;
    capture_frame(cath, lowc, acks, bad);
    n_total++; if (cath !== 32'h2525_2525 || acks != 1)
      $display("FAIL b2b_2222: got %h acks=%0d expected 25252525 acks=1", cath, acks); else n_pass++;
    capture_frame(cath, lowc, acks, bad);
    n_total++; if (cath !== 32'h0D99_4941 || acks != 1)
      $display("FAIL b2b_3456: got %h acks=%0d expected 0d994941 acks=1", cath, acks); else n_pass++;
    capture_frame(cath, lowc, acks, bad);
    n_total++; if (acks != 0) $display("FAIL b2b_no_extra_ack: got %0d expected 0", acks); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] cath, lowc;
    int acks, bad;
    bit ok;
    pulse_load(16'h1234, 4'b1111, 4'b1111);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++; if (An !== 4'b1111 || Cath !== 8'hFF)
      $display("FAIL async_reset: got %b/%h expected 1111/ff", An, Cath); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_fs(ok, acks);
    n_total++; if (!ok || acks != 0) $display("FAIL rst_wait: got ok=%0d acks=%0d expected 1/0", ok, acks); else n_pass++;
    capture_frame(cath, lowc, acks, bad);
    n_total++; if (cath !== 32'h0303_0303 || acks != 0)
      $display("FAIL rst_resume: got %h acks=%0d expected 03030303 acks=0", cath, acks); else n_pass++;
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    rst            = 1'b1;
    bus.value      = '0;
    bus.dp         = '0;
    bus.digit_en   = '1;
    bus.load       = 1'b0;
    bus.lz_blank   = 1'b0;
    bus.brightness = 4'd15;
    test_reset();
    test_load_mid_frame();
    test_lz_blank();
    test_pwm_enable();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Parametrised, multiplexed seven-segment display driver for the Nexys4 board. It replaces the fixed four-digit scan logic in the top level. It supports 1–8 digits, a configurable scan rate, per-digit enable and decimal point, leading-zero blanking, 16-level PWM brightness, and a double-buffered load so a new value never tears mid-frame. It sits between game/score logic and the board pins An*/Ca..Cg/Dp.

## Interface
Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..8)
- SCAN_DIV_LOG2, 18, log2 of clock cycles per digit slot (≥4); 18 gives ≈381 Hz per digit at 100 MHz

Ports:
- ClkPort  in  1  system clock, 100 MHz
- Reset  in  1  asynchronous, active-high
- value  in  4*NUM_DIGITS  hex nibbles; nibble i is digit i (digit 0 = rightmost)
- dp  in  NUM_DIGITS  1 = decimal point lit for digit i
- digit_en  in  NUM_DIGITS  1 = digit i participates; 0 = anode never driven
- load  in  1  strobe; captures value/dp/digit_en into the pending buffer
- lz_blank  in  1  1 = suppress leading zeros (live, not buffered)
- brightness  in  4  PWM duty level (live, not buffered)
- An  out  NUM_DIGITS  anodes, active-low
- Cath  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
- load_ack  out  1  one-cycle pulse when the pending buffer becomes active
- frame_start  out  1  one-cycle pulse at every frame boundary

## Operation
- **Prescaler:** free-running SCAN_DIV_LOG2-bit up-counter. It wraps all-ones→0.
- **Digit index:** advances on each wrap, 0→NUM_DIGITS-1→0.
- **Frame boundary:** the cycle in which the prescaler wraps while idx = NUM_DIGITS-1.
- **Buffers:** active registers (value, dp, digit_en) feed the display. Pending registers plus a pending flag receive loads.
- **load=1:** pending ← inputs, flag ← 1. Latest load wins. Several loads before a boundary produce one ack.
- **At a frame boundary with flag=1:** active ← pending, flag ← 0, load_ack pulses.
- **load in the boundary cycle:** the previous pending content (if any) is applied. The new load is captured, flag stays 1, and it is applied at the next boundary.
- **Leading-zero blanking (lz_blank=1):** starting from digit NUM_DIGITS-1 and scanning down, digits whose active nibble is 0 are blanked until the first nonzero digit. Digit 0 is never blanked.
  - A blanked digit drives segments a–g off.
  - Dp still follows dp[i], and the anode still pulses.
- **Decode:** standard hex font, abcdefg active-low.
  - Examples: 0 = 0000001, 1 = 1001111, 2 = 0010010, 5 = 0100100, 8 = 0000000, A = 0001000, F = 0111000.
  - Dp = ~dp[idx].
- **PWM:** phase = prescaler[SCAN_DIV_LOG2-1 -: 4]. An[idx] is driven low iff digit_en[idx] && phase ≤ brightness.
  - Duty is (brightness+1)/16; 15 = full.
  - All other anodes are high.
- **Reset values:**
  - prescaler 0, idx 0, pending flag 0.
  - Active value 0, active dp 0, active digit_en all 1.
  - An all 1, Cath 8'hFF, load_ack 0, frame_start 0.
- **Reset mid-operation:** asynchronous clear. A pending load is discarded and no ack is issued.

## Timing
- An, Cath, load_ack and frame_start are registered: one cycle after the internal state that produces them.
- First cycle after Reset deasserts: the counter advances. The next cycle shows An[0]=0 with the '0' pattern.
- Digit slot is 2^SCAN_DIV_LOG2 cycles. Frame is NUM_DIGITS × slot.
- Load-to-ack latency: 2 to frame+1 cycles. New values appear on the pins in the same cycle as load_ack.
- frame_start and load_ack coincide. They are visible in the cycle in which digit 0's first slot is displayed.
- lz_blank and brightness changes take effect on the next output register update (1 cycle).

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV_LOG2=4, brightness=15 unless stated.
1. Reset held → An=4'b1111, Cath=8'hFF. After release → An cycles 1110, 1101, 1011, 0111, changing every 16 cycles; Cath=8'b00000011 throughout; frame_start pulses every 64 cycles.
2. load with value=16'h12AF, dp=4'b0100 mid-frame → pins keep showing 0 until the boundary. Then exactly one load_ack pulse. Digits show F (0111000), A, 2, 1; digit 2 has Dp=0.
3. lz_blank=1, load 16'h0050 → digits 3 and 2 show Cath=8'hFF while anodes still pulse; digit 1 shows '5'; digit 0 shows '0'. Load 16'h0000 → only digit 0 shows '0'.
4. brightness=3 → each An low for exactly 4 of 16 cycles per slot (phase 0–3). brightness=0 → 1 cycle. digit_en=4'b1011 after load → An[2] stays high all frame.
5. Two loads (16'h1111 then 16'h2222) inside one frame, plus a third load in the boundary cycle → 2222 is displayed with one ack. The third value is displayed at the following boundary with a second ack.
6. Load issued, then Reset pulsed before the boundary → outputs go off immediately. No load_ack afterwards. Display resumes showing 0000.
